// File: rtl/round_scorer_if.sv
// Signal bundle between the tug-of-war field logic / top level and the round scorer.
interface round_scorer_if;
  logic       win1;
  logic       win2;
  logic       field_reset;
  logic [2:0] score1;
  logic [2:0] score2;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic       match_over;
  logic [1:0] match_winner;

  modport master (
    output win1, win2,
    input  field_reset, score1, score2, hex1, hex2, match_over, match_winner
  );

  modport slave (
    input  win1, win2,
    output field_reset, score1, score2, hex1, hex2, match_over, match_winner
  );
endinterface

// File: rtl/round_scorer.sv
// Match-level scorekeeper: counts round wins from light_control, freezes the field
// between rounds, re-centres it with field_reset and declares the match winner.
module round_scorer #(
  parameter int MAX_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  round_scorer_if.slave bus
);

  localparam int             CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [2:0]     MAX      = 3'(MAX_SCORE);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state, w_nextState;
  logic [CW-1:0] r_cnt, w_nextCnt;
  logic [2:0]    r_score1, r_score2, w_nextScore1, w_nextScore2;
  logic          r_win1D, r_win2D;
  logic          r_fieldReset, r_matchOver;
  logic [1:0]    r_matchWinner;
  logic          w_rise1, w_rise2;

  assign w_rise1 = bus.win1 & ~r_win1D;
  assign w_rise2 = bus.win2 & ~r_win2D;

  always_comb begin
    w_nextState  = r_state;
    w_nextCnt    = r_cnt;
    w_nextScore1 = r_score1;
    w_nextScore2 = r_score2;
    case (r_state)
      PLAY: begin
        if (w_rise1 | w_rise2) begin
          w_nextState = HOLD;
          w_nextCnt   = CNT_LOAD;
          // Simultaneous rises are a draw: freeze and re-centre, but nobody scores.
          if (w_rise1 && !w_rise2 && r_score1 < MAX) w_nextScore1 = r_score1 + 3'd1;
          if (w_rise2 && !w_rise1 && r_score2 < MAX) w_nextScore2 = r_score2 + 3'd1;
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_nextState = (r_score1 == MAX || r_score2 == MAX) ? DONE : PLAY;
        end else begin
          w_nextCnt = r_cnt - CW'(1);
        end
      end
      DONE: begin
        w_nextState = DONE;
      end
      default: begin
        w_nextState = PLAY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= PLAY;
      r_cnt         <= '0;
      r_score1      <= 3'd0;
      r_score2      <= 3'd0;
      r_win1D       <= 1'b1;
      r_win2D       <= 1'b1;
      r_fieldReset  <= 1'b0;
      r_matchOver   <= 1'b0;
      r_matchWinner <= 2'b00;
    end else begin
      r_state      <= w_nextState;
      r_cnt        <= w_nextCnt;
      r_score1     <= w_nextScore1;
      r_score2     <= w_nextScore2;
      r_win1D      <= bus.win1;
      r_win2D      <= bus.win2;
      // One-cycle pulse on leaving HOLD for PLAY; held high for the whole of DONE.
      r_fieldReset <= (w_nextState == DONE) || (r_state == HOLD && w_nextState == PLAY);
      r_matchOver  <= (w_nextState == DONE);
      if (w_nextState == DONE) begin
        r_matchWinner <= (w_nextScore1 == MAX) ? 2'b10 : 2'b01;
      end else begin
        r_matchWinner <= 2'b00;
      end
    end
  end

  function automatic logic [6:0] hexEncode(input logic [2:0] value);
    case (value)
      3'd0:    hexEncode = 7'b1000000;
      3'd1:    hexEncode = 7'b1111001;
      3'd2:    hexEncode = 7'b0100100;
      3'd3:    hexEncode = 7'b0110000;
      3'd4:    hexEncode = 7'b0011001;
      3'd5:    hexEncode = 7'b0010010;
      3'd6:    hexEncode = 7'b0000010;
      3'd7:    hexEncode = 7'b1111000;
      default: hexEncode = 7'b1111111;
    endcase
  endfunction

  assign bus.score1       = r_score1;
  assign bus.score2       = r_score2;
  assign bus.hex1         = hexEncode(r_score1);
  assign bus.hex2         = hexEncode(r_score2);
  assign bus.field_reset  = r_fieldReset;
  assign bus.match_over   = r_matchOver;
  assign bus.match_winner = r_matchWinner;

endmodule

// File: tb/tb_round_scorer.sv
// Directed self-checking bench for round_scorer (MAX_SCORE=7, HOLD_CYCLES=4).
module tb_round_scorer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  round_scorer_if bus ();

  round_scorer #(
    .MAX_SCORE  (7),
    .HOLD_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference table for the active-low seven-segment digits.
  function automatic logic [6:0] expHex(input int v);
    case (v)
      0:       expHex = 7'b1000000;
      1:       expHex = 7'b1111001;
      2:       expHex = 7'b0100100;
      3:       expHex = 7'b0110000;
      4:       expHex = 7'b0011001;
      5:       expHex = 7'b0010010;
      6:       expHex = 7'b0000010;
      7:       expHex = 7'b1111000;
      default: expHex = 7'b1111111;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setWin(input int p, input logic v);
    if (p == 1) bus.win1 = v;
    else        bus.win2 = v;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.win1 = 1'b0; bus.win2 = 1'b0;
    tick; tick;
    checks++;
    if (bus.score1 !== 3'd0 || bus.score2 !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_scores: got %0d/%0d expected 0/0", bus.score1, bus.score2);
    end
    checks++;
    if (bus.field_reset !== 1'b0 || bus.match_over !== 1'b0 || bus.match_winner !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_flags: got fr=%b mo=%b mw=%b expected 0 0 00",
               bus.field_reset, bus.match_over, bus.match_winner);
    end
    checks++;
    if (bus.hex1 !== 7'b1000000 || bus.hex2 !== 7'b1000000) begin
      errors++; $display("[TB] FAIL reset_hex: got %b/%b expected 1000000", bus.hex1, bus.hex2);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single_win;
    bus.win1 = 1'b1;
    tick;
    checks++;
    if (bus.score1 !== 3'd1 || bus.score2 !== 3'd0) begin
      errors++; $display("[TB] FAIL single_score: got %0d/%0d expected 1/0", bus.score1, bus.score2);
    end
    checks++;
    if (bus.hex1 !== 7'b1111001) begin
      errors++; $display("[TB] FAIL single_hex1: got %b expected 1111001", bus.hex1);
    end
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) bus.win1 = 1'b0;
      tick;
      checks++;
      if (bus.field_reset !== (i == 4)) begin
        errors++; $display("[TB] FAIL single_fr_%0d: got %b expected %b", i, bus.field_reset, (i == 4));
      end
    end
    checks++;
    if (bus.score1 !== 3'd1) begin
      errors++; $display("[TB] FAIL single_final: got %0d expected 1", bus.score1);
    end
  endtask

  task automatic test_held_win;
    bus.win1 = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) tick;
    checks++;
    if (bus.score1 !== 3'd2) begin
      errors++; $display("[TB] FAIL held_once: got %0d expected 2", bus.score1);
    end
    bus.win1 = 1'b0;
    tick;
    bus.win1 = 1'b1;
    tick;
    checks++;
    if (bus.score1 !== 3'd3 || bus.hex1 !== 7'b0110000) begin
      errors++; $display("[TB] FAIL held_rerise: got %0d/%b expected 3/0110000", bus.score1, bus.hex1);
    end
    bus.win1 = 1'b0;
    for (int i = 0; i < 6; i++) tick;
  endtask

  task automatic test_draw;
    bus.win1 = 1'b1; bus.win2 = 1'b1;
    tick;
    bus.win1 = 1'b0; bus.win2 = 1'b0;
    checks++;
    if (bus.score1 !== 3'd3 || bus.score2 !== 3'd0) begin
      errors++; $display("[TB] FAIL draw_scores: got %0d/%0d expected 3/0", bus.score1, bus.score2);
    end
    for (int i = 1; i <= 6; i++) begin
      tick;
      checks++;
      if (bus.field_reset !== (i == 4)) begin
        errors++; $display("[TB] FAIL draw_fr_%0d: got %b expected %b", i, bus.field_reset, (i == 4));
      end
    end
  endtask

  task automatic test_mid_reset;
    bus.win2 = 1'b1;
    tick;
    bus.win2 = 1'b0;
    checks++;
    if (bus.score2 !== 3'd1) begin
      errors++; $display("[TB] FAIL midreset_pre: got %0d expected 1", bus.score2);
    end
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if (bus.score1 !== 3'd0 || bus.score2 !== 3'd0 || bus.field_reset !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_state: got %0d/%0d fr=%b expected 0/0 fr=0",
               bus.score1, bus.score2, bus.field_reset);
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++;
      if (bus.field_reset !== 1'b0) begin
        errors++; $display("[TB] FAIL midreset_fr_%0d: got %b expected 0", i, bus.field_reset);
      end
    end
  endtask

  task automatic test_reset_high_win;
    reset = 1'b1; bus.win1 = 1'b1;
    tick; tick;
    reset = 1'b0;
    tick; tick;
    checks++;
    if (bus.score1 !== 3'd0) begin
      errors++; $display("[TB] FAIL highwin_noscore: got %0d expected 0", bus.score1);
    end
    bus.win1 = 1'b0;
    tick;
    bus.win1 = 1'b1;
    tick;
    bus.win1 = 1'b0;
    checks++;
    if (bus.score1 !== 3'd1) begin
      errors++; $display("[TB] FAIL highwin_fresh: got %0d expected 1", bus.score1);
    end
    for (int i = 0; i < 6; i++) tick;
  endtask

  task automatic test_match(input int p);
    logic [2:0] own, other;
    logic [1:0] expWinner;
    expWinner = (p == 1) ? 2'b10 : 2'b01;
    reset = 1'b1; bus.win1 = 1'b0; bus.win2 = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    for (int k = 1; k <= 7; k++) begin
      setWin(p, 1'b1);
      tick;
      setWin(p, 1'b0);
      own   = (p == 1) ? bus.score1 : bus.score2;
      other = (p == 1) ? bus.score2 : bus.score1;
      checks++;
      if (own !== 3'(k) || other !== 3'd0) begin
        errors++; $display("[TB] FAIL match%0d_score_%0d: got %0d/%0d expected %0d/0", p, k, own, other, k);
      end
      checks++;
      if (((p == 1) ? bus.hex1 : bus.hex2) !== expHex(k)) begin
        errors++;
        $display("[TB] FAIL match%0d_hex_%0d: got %b expected %b", p, k,
                 (p == 1) ? bus.hex1 : bus.hex2, expHex(k));
      end
      for (int i = 1; i <= 5; i++) begin
        tick;
        if (k == 7) begin
          checks++;
          if (bus.match_over !== (i >= 4) || bus.field_reset !== (i >= 4) ||
              bus.match_winner !== ((i >= 4) ? expWinner : 2'b00)) begin
            errors++;
            $display("[TB] FAIL match%0d_done_%0d: got mo=%b fr=%b mw=%b expected mo=%b fr=%b mw=%b",
                     p, i, bus.match_over, bus.field_reset, bus.match_winner,
                     (i >= 4), (i >= 4), (i >= 4) ? expWinner : 2'b00);
          end
        end else begin
          checks++;
          if (bus.field_reset !== (i == 4) || bus.match_over !== 1'b0) begin
            errors++;
            $display("[TB] FAIL match%0d_round_%0d_%0d: got fr=%b mo=%b expected fr=%b mo=0",
                     p, k, i, bus.field_reset, bus.match_over, (i == 4));
          end
        end
      end
    end
    setWin(3 - p, 1'b1);
    tick;
    setWin(p, 1'b1);
    tick; tick;
    setWin(1, 1'b0); setWin(2, 1'b0);
    own   = (p == 1) ? bus.score1 : bus.score2;
    other = (p == 1) ? bus.score2 : bus.score1;
    checks++;
    if (own !== 3'd7 || other !== 3'd0 || bus.field_reset !== 1'b1 || bus.match_over !== 1'b1 ||
        bus.match_winner !== expWinner) begin
      errors++;
      $display("[TB] FAIL match%0d_frozen: got %0d/%0d fr=%b mo=%b mw=%b expected 7/0 fr=1 mo=1 mw=%b",
               p, own, other, bus.field_reset, bus.match_over, bus.match_winner, expWinner);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.win1 = 1'b0;
    bus.win2 = 1'b0;
    test_reset();
    test_single_win();
    test_held_win();
    test_draw();
    test_mid_reset();
    test_reset_high_win();
    test_match(2);
    test_match(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
